zrom_arb: RTL and testbench

Arbiter and sequencer for the shared Z80 M1 ROM memory port. It sits between the Z80 bank-window translator, the cartridge loader and the 16-bit external memory channel. Z80 byte reads at translated ROM addresses are turned into word reads, and the Z80 is held in wait until data returns. Loader word writes are interleaved into idle slots, and a stalled memory access is bounded by a timeout.

---
 rtl/zrom_arb.sv | 193 +++++++++++++++++++
 tb/tb_zrom_arb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zrom_arb.sv
// zrom_arb: arbiter/sequencer for the shared Z80 M1 ROM port; Z80 byte reads win over loader word writes.
// Optional feature: define ZROM_LASTHIT_EN for a single-word last-hit read cache.
module zrom_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        nSDMRD,
    input  logic [18:0] z80_addr,
    output logic        nWAIT,
    output logic [7:0]  z80_dout,
    input  logic        ld_req,
    input  logic [17:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    // Memory handshake: mem_req, mem_we, mem_addr and mem_wdata stay stable from the edge that
    // raises mem_req until the edge that samples mem_ack high (or the timeout); mem_req then drops
    // for at least one cycle. ld_req is a level held by the loader until it sees the ld_ack pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic        nsdmrd_d;
    logic        z80_pend, z80_pend_nx;
    logic [18:0] z80_lat, z80_lat_nx;
    logic        nwait_nx;
    logic [7:0]  dout_nx;
    logic        ld_ack_nx;
    logic        mem_req_nx, mem_we_nx;
    logic [17:0] mem_addr_nx;
    logic [15:0] mem_wdata_nx;
    logic        err_nx;
    logic [7:0]  tmo_cnt, tmo_cnt_nx;
    logic [8:0]  tmo_inc;
    logic        rd_fall, tmo_hit, cache_hit;
    logic [7:0]  hit_byte;

    assign rd_fall = !nSDMRD && nsdmrd_d;
    assign tmo_inc = {1'b0, tmo_cnt} + 9'd1;
    assign tmo_hit = (tmo_inc == 9'(TIMEOUT));

`ifdef ZROM_LASTHIT_EN
    logic        c_valid;
    logic [17:0] c_tag;
    logic [15:0] c_data;
    logic        wr_start;

    assign wr_start  = (state == ST_IDLE) && (state_nx == ST_WR);
    assign cache_hit = c_valid && (c_tag == z80_lat[18:1]);
    assign hit_byte  = z80_lat[0] ? c_data[15:8] : c_data[7:0];

    // Filled only by acknowledged reads; any loader write to the tagged word invalidates it.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            c_valid <= 1'b0;
            c_tag   <= '0;
            c_data  <= '0;
        end else if (state == ST_RD && mem_ack) begin
            c_valid <= 1'b1;
            c_tag   <= mem_addr;
            c_data  <= mem_rdata;
        end else if (wr_start && ld_addr == c_tag) begin
            c_valid <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_byte  = 8'hFF;
`endif

    always_comb begin
        state_nx     = state;
        z80_pend_nx  = z80_pend;
        z80_lat_nx   = z80_lat;
        nwait_nx     = nWAIT;
        dout_nx      = z80_dout;
        ld_ack_nx    = 1'b0;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        err_nx       = err;
        tmo_cnt_nx   = tmo_cnt;

        // A strobe edge while a read is still pending is dropped.
        if (rd_fall && !z80_pend) begin
            z80_pend_nx = 1'b1;
            z80_lat_nx  = z80_addr;
            nwait_nx    = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (z80_pend) begin
                    if (cache_hit) begin
                        dout_nx     = hit_byte;
                        nwait_nx    = 1'b1;
                        z80_pend_nx = 1'b0;
                    end else begin
                        state_nx    = ST_RD;
                        mem_req_nx  = 1'b1;
                        mem_we_nx   = 1'b0;
                        mem_addr_nx = z80_lat[18:1];
                        tmo_cnt_nx  = '0;
                    end
                end else if (ld_req && !ld_ack && !rd_fall) begin
                    // While ld_ack is high the loader has not yet dropped its finished request.
                    state_nx     = ST_WR;
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = 1'b1;
                    mem_addr_nx  = ld_addr;
                    mem_wdata_nx = ld_data;
                    tmo_cnt_nx   = '0;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    dout_nx     = z80_lat[0] ? mem_rdata[15:8] : mem_rdata[7:0];
                    nwait_nx    = 1'b1;
                    z80_pend_nx = 1'b0;
                    mem_req_nx  = 1'b0;
                    state_nx    = ST_IDLE;
                end else if (tmo_hit) begin
                    dout_nx     = 8'hFF;
                    nwait_nx    = 1'b1;
                    z80_pend_nx = 1'b0;
                    mem_req_nx  = 1'b0;
                    err_nx      = 1'b1;
                    state_nx    = ST_IDLE;
                end else begin
                    tmo_cnt_nx = tmo_inc[7:0];
                end
            end
            ST_WR: begin
                if (mem_ack || tmo_hit) begin
                    ld_ack_nx  = 1'b1;
                    mem_req_nx = 1'b0;
                    mem_we_nx  = 1'b0;
                    err_nx     = err | !mem_ack;
                    state_nx   = ST_IDLE;
                end else begin
                    tmo_cnt_nx = tmo_inc[7:0];
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= ST_IDLE;
            nsdmrd_d  <= 1'b1;
            z80_pend  <= 1'b0;
            z80_lat   <= '0;
            nWAIT     <= 1'b1;
            z80_dout  <= 8'hFF;
            ld_ack    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_nx;
            nsdmrd_d  <= nSDMRD;
            z80_pend  <= z80_pend_nx;
            z80_lat   <= z80_lat_nx;
            nWAIT     <= nwait_nx;
            z80_dout  <= dout_nx;
            ld_ack    <= ld_ack_nx;
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            err       <= err_nx;
            tmo_cnt   <= tmo_cnt_nx;
        end
    end

endmodule

// File: tb/tb_zrom_arb.sv
// Bench for zrom_arb: directed steps plus randomized reads/writes checked against a behavioural
// model of the ROM contents and the last-hit cache.
`timescale 1ns/1ps
module tb_zrom_arb;

    localparam int TMO = 4;
`ifdef ZROM_LASTHIT_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        nSDMRD = 1'b1;
    logic [18:0] z80_addr = '0;
    logic        nWAIT;
    logic [7:0]  z80_dout;
    logic        ld_req = 1'b0;
    logic [17:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        ld_ack;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack;
    logic        err;

    logic mem_ack_r = 1'b0;
    logic ack_inj = 1'b0;
    assign mem_ack = mem_ack_r | ack_inj;

    int checks = 0;
    int errors = 0;

    // Memory responder state and observation logs
    int  mem_lat = 1;
    bit  mem_hang = 1'b0;
    int  req_cycles = 0;
    int  req_hi = 0;
    int  low_run = 0;
    int  last_gap = -1;
    int  ld_ack_pulses = 0;
    logic [34:0] txn_q[$];
    logic [15:0] mem_arr [logic [17:0]];

    // Reference model: expected ROM contents and last-hit cache state
    logic [15:0] exp_mem [logic [17:0]];
    bit          ref_valid = 1'b0;
    logic [17:0] ref_tag = '0;
    logic [17:0] pool [4] = '{18'h00008, 18'h00009, 18'h07800, 18'h3FFFF};

    zrom_arb #(.TIMEOUT(TMO)) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .nSDMRD    (nSDMRD),
        .z80_addr  (z80_addr),
        .nWAIT     (nWAIT),
        .z80_dout  (z80_dout),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ack    (ld_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] dflt(input logic [17:0] w);
        return {w[7:0], w[15:8]} ^ 16'hC35A;
    endfunction

    function automatic logic [15:0] mem_word(input logic [17:0] w);
        return mem_arr.exists(w) ? mem_arr[w] : dflt(w);
    endfunction

    function automatic logic [15:0] model_word(input logic [17:0] w);
        return exp_mem.exists(w) ? exp_mem[w] : dflt(w);
    endfunction

    // Memory: acks the mem_lat-th cycle of each request, never when hung
    always @(posedge CLK) begin
        #1;
        mem_ack_r = 1'b0;
        if (ld_ack === 1'b1) ld_ack_pulses++;
        if (mem_req === 1'b1) begin
            if (req_cycles == 0) begin
                txn_q.push_back({mem_we, mem_addr, mem_wdata});
                last_gap = low_run;
            end
            req_cycles++;
            req_hi++;
            low_run = 0;
            if (!mem_hang && req_cycles == mem_lat) begin
                mem_ack_r = 1'b1;
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
                else        mem_rdata = mem_word(mem_addr);
            end
        end else begin
            req_cycles = 0;
            low_run++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_read(input logic [18:0] a, input bit hang);
        logic [17:0] w;
        bit          hit;
        int          n0;
        int          cyc;
        logic [15:0] word;
        logic [7:0]  exp_b;
        int          exp_wait;
        w        = a[18:1];
        hit      = CACHE_ON && ref_valid && (ref_tag == w);
        word     = model_word(w);
        exp_b    = (hang && !hit) ? 8'hFF : (a[0] ? word[15:8] : word[7:0]);
        exp_wait = hit ? 1 : (hang ? TMO + 1 : mem_lat + 1);
        n0       = txn_q.size();
        @(negedge CLK);
        nSDMRD   = 1'b0;
        z80_addr = a;
        tick();
        cyc = 0;
        while (nWAIT === 1'b0 && cyc < 64) begin
            cyc++;
            tick();
        end
        chk("rd_wait", cyc, exp_wait);
        chk("rd_data", z80_dout, exp_b);
        chk("rd_txn_cnt", txn_q.size() - n0, hit ? 0 : 1);
        if (!hit && txn_q.size() > n0) chk("rd_txn_addr", txn_q[n0][34:16], {1'b0, w});
        if (!hit && !hang) begin
            ref_valid = 1'b1;
            ref_tag   = w;
        end
        @(negedge CLK);
        nSDMRD = 1'b1;
        tick();
    endtask

    task automatic ld_write(input logic [17:0] a, input logic [15:0] d, input bit hang);
        int n0;
        int p0;
        int cyc;
        n0 = txn_q.size();
        p0 = ld_ack_pulses;
        @(negedge CLK);
        ld_req  = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        cyc = 0;
        while (ld_ack !== 1'b1 && cyc < 64) begin
            cyc++;
            tick();
        end
        ld_req = 1'b0;
        chk("ld_ack_seen", ld_ack, 1'b1);
        tick();
        chk("ld_ack_pulses", ld_ack_pulses - p0, 1);
        chk("wr_txn_cnt", txn_q.size() - n0, 1);
        if (txn_q.size() > n0) chk("wr_txn", txn_q[n0], {1'b1, a, d});
        if (!hang) exp_mem[a] = d;
        if (ref_valid && ref_tag == a) ref_valid = 1'b0;
    endtask

    initial begin
        int n0;
        int p0;
        int r0;
        int cyc;
        bit rd_done;
        bit wr_done;
        logic [15:0] ew;

        mem_arr[18'h07800] = 16'hABCD;
        exp_mem[18'h07800] = 16'hABCD;

        // Reset with mem_ack low
        tick(); tick(); tick();
        chk("rst_nwait", nWAIT, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_dout", z80_dout, 8'hFF);
        chk("rst_ld_ack", ld_ack, 1'b0);
        chk("rst_mem_addr", mem_addr, 18'h0);
        @(negedge CLK);
        nRESET = 1'b1;
        tick();

        // Basic read, one-cycle memory
        mem_lat = 1;
        check_read(19'h0F001, 1'b0);

        // Z80 strobe and loader request sampled on the same edge
        n0 = txn_q.size();
        p0 = ld_ack_pulses;
        @(negedge CLK);
        nSDMRD   = 1'b0;
        z80_addr = 19'h2468B;
        ld_req   = 1'b1;
        ld_addr  = 18'h00155;
        ld_data  = 16'h1357;
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        cyc      = 0;
        ew       = model_word(18'h12345);
        tick();
        while (!(rd_done && wr_done) && cyc < 64) begin
            if (!rd_done && nWAIT === 1'b1) begin
                rd_done = 1'b1;
                chk("both_rd_data", z80_dout, ew[15:8]);
            end
            if (!wr_done && ld_ack === 1'b1) begin
                wr_done = 1'b1;
                ld_req  = 1'b0;
            end
            cyc++;
            tick();
        end
        chk("both_done", {rd_done, wr_done}, 2'b11);
        chk("both_txn_cnt", txn_q.size() - n0, 2);
        if (txn_q.size() >= n0 + 2) begin
            chk("both_first_rd", txn_q[n0][34:16], {1'b0, 18'h12345});
            chk("both_second_wr", txn_q[n0 + 1], {1'b1, 18'h00155, 16'h1357});
        end
        chk("both_gap", last_gap, 1);
        chk("both_ld_ack_pulses", ld_ack_pulses - p0, 1);
        ref_valid = 1'b1;
        ref_tag   = 18'h12345;
        exp_mem[18'h00155] = 16'h1357;
        @(negedge CLK);
        nSDMRD = 1'b1;
        tick();

        // Last-hit sequence: low byte, high byte of same word, loader write, re-read
        check_read(19'h00010, 1'b0);
        check_read(19'h00011, 1'b0);
        ld_write(18'h00008, 16'hBEEF, 1'b0);
        check_read(19'h00010, 1'b0);

        // Randomized mix over a small address pool
        for (int i = 0; i < 24; i++) begin
            int          op;
            logic [17:0] w;
            op      = $urandom_range(0, 2);
            w       = pool[$urandom_range(0, 3)];
            mem_lat = $urandom_range(1, 3);
            if (op == 2) ld_write(w, 16'($urandom), 1'b0);
            else         check_read({w, 1'($urandom_range(0, 1))}, 1'b0);
        end

        // Ack on the same edge as the timeout is a normal completion
        mem_lat = TMO;
        check_read(19'h01235, 1'b0);
        ld_write(18'h00777, 16'h4242, 1'b0);
        chk("ack_at_tmo_err", err, 1'b0);

        // Hung memory: read and write both time out
        mem_hang = 1'b1;
        r0 = req_hi;
        check_read(19'h05551, 1'b1);
        chk("tmo_req_cycles", req_hi - r0, TMO);
        chk("tmo_err", err, 1'b1);
        chk("tmo_nwait", nWAIT, 1'b1);
        ld_write(18'h2AAAA, 16'h9999, 1'b1);
        chk("tmo_wr_err", err, 1'b1);
        mem_hang = 1'b0;
        mem_lat  = 2;
        check_read(19'h05551, 1'b0);
        check_read(19'h55554, 1'b0);
        chk("err_sticky", err, 1'b1);

        // Reset while a read is in flight, then a stray ack after release
        mem_hang = 1'b1;
        @(negedge CLK);
        nSDMRD   = 1'b0;
        z80_addr = 19'h00100;
        tick(); tick(); tick();
        chk("rst_mid_pre_req", mem_req, 1'b1);
        #1;
        nRESET = 1'b0;
        nSDMRD = 1'b1;
        #1;
        chk("rst_mid_async_req", mem_req, 1'b0);
        chk("rst_mid_async_nwait", nWAIT, 1'b1);
        mem_hang  = 1'b0;
        ref_valid = 1'b0;
        @(negedge CLK);
        nRESET  = 1'b1;
        ack_inj = 1'b1;
        n0 = txn_q.size();
        r0 = req_hi;
        tick();
        ack_inj = 1'b0;
        tick();
        chk("late_ack_req", mem_req, 1'b0);
        chk("late_ack_nwait", nWAIT, 1'b1);
        chk("late_ack_dout", z80_dout, 8'hFF);
        chk("late_ack_ld_ack", ld_ack, 1'b0);
        chk("late_ack_err", err, 1'b0);
        chk("late_ack_txn", txn_q.size() - n0, 0);
        chk("late_ack_req_hi", req_hi - r0, 0);

        mem_lat = 1;
        check_read(19'h0F001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
